dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Sits in front of dmem and shares its single port between the CPU load/store unit
//  (port C, high priority) and a DMA/debug loader (port D, valid/ready).
//  Handles CPU sub-word sizing: generates byte enables, lane-shifts store data,
//  and extracts/sign-extends load data. A starvation counter bounds DMA wait time.
// PARAMETERS
//  AW           14  byte address width (matches dmem addr)
//  STARVE_LIMIT 8   consecutive denied DMA cycles before DMA is forced a grant (>=1)
//  CW           4   starvation counter width; must hold STARVE_LIMIT
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  cpu_req      in   1   CPU access this cycle
//  cpu_we       in   1   1=store, 0=load
//  cpu_size     in   2   0=byte, 1=half, 2=word (3 treated as word)
//  cpu_unsigned in   1   load zero-extend (1) / sign-extend (0)
//  cpu_addr     in   AW  byte address
//  cpu_wdata    in   32  store data, LSB-justified
//  cpu_rdata    out  32  load data, aligned and extended
//  cpu_stall    out  1   CPU access not performed this cycle; hold request
//  cpu_misalign out  1   access misaligned; access dropped
//  dma_valid    in   1   DMA request pending
//  dma_ready    out  1   DMA request accepted this cycle
//  dma_we       in   1   1=write, 0=read
//  dma_be       in   4   write byte enables
//  dma_addr     in   AW  byte address; bits [1:0] ignored
//  dma_wdata    in   32  write data
//  dma_rvalid   out  1   registered read data valid (one-cycle pulse)
//  dma_rdata    out  32  registered read data
//  mem_en       out  1   to dmem en
//  mem_we       out  4   to dmem we
//  mem_addr     out  AW  to dmem addr
//  mem_din      out  32  to dmem din
//  mem_dout     in   32  from dmem dout (combinational read)
// BEHAVIOUR
//  Grant is decided combinationally each cycle:
//   force   = dma_valid && starve_cnt == STARVE_LIMIT
//   gnt_dma = dma_valid && (!cpu_req || force);  gnt_cpu = cpu_req && !gnt_dma
//  dma_ready = gnt_dma; cpu_stall = cpu_req && gnt_dma. With no grant: mem_en=0, mem_we=0.
//  starve_cnt (register): reset 0; cleared when dma_ready or !dma_valid;
//   incremented when dma_valid && !dma_ready; saturates at STARVE_LIMIT.
//  CPU path (gnt_cpu): misaligned = half && addr[0], or word && addr[1:0]!=0.
//   cpu_misalign = cpu_req && misaligned (regardless of grant); misaligned store drives
//   mem_we=0, and cpu_rdata=0 on misaligned load.
//   Store byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//   mem_din = wdata replicated to all lanes (byte x4, half x2, word as-is).
//   Load: lane = mem_dout >> (8*addr[1:0]); low 8/16/32 bits, zero/sign-extended
//   per cpu_unsigned. cpu_rdata is combinational: same cycle as request. Stores commit
//   at the rising edge ending the granted cycle. cpu_rdata=0 whenever !gnt_cpu.
//  DMA path (gnt_dma): mem_we = dma_we ? dma_be : 0, mem_din = dma_wdata.
//   Read: dma_rdata <= mem_dout and dma_rvalid <= 1 at the accepting edge; dma_rvalid
//   is 0 in every other cycle. dma_rdata holds its value until the next DMA read.
//   DMA write produces no rvalid.
//  mem_addr = granted port's address (CPU when neither).
//  Reset (async, any time incl. mid-burst): starve_cnt=0, dma_rvalid=0, dma_rdata=0;
//   combinational outputs follow inputs; a pending rvalid is lost on reset.
//  Back-to-back DMA requests accepted every cycle when CPU idle; no internal queue.
// TESTING
//  1 CPU sw 0xDEADBEEF @0x010, lw @0x010 -> mem_we=4'hF, cpu_rdata=0xDEADBEEF, stall=0.
//  2 CPU sb 0x80 @0x013; lb @0x013 -> mem_we=4'b1000, rdata=0xFFFFFF80; lbu -> 0x00000080.
//  3 CPU lh @0x011 -> cpu_misalign=1, mem_we=0, rdata=0; sw @0x012 -> no write occurs.
//  4 cpu_req held high, dma_valid high, STARVE_LIMIT=8 -> dma_ready first in 9th cycle,
//    cpu_stall=1 that cycle only, starve_cnt back to 0 next cycle.
//  5 CPU idle, DMA reads 0x020,0x024 back-to-back -> dma_rvalid on consecutive cycles,
//    dma_rdata matches preloaded words, one cycle after each accept.
//  6 Assert rst_n=0 during DMA read accept cycle -> dma_rvalid=0, starve_cnt=0 immediately.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, DMA and dmem signals shared by the data-memory arbiter.
// The slave side is the arbiter; the master side is everything around it.
interface dmem_arbiter_if #(
    parameter int AW = 14
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [1:0]    cpu_size;
    logic          cpu_unsigned;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic [31:0]   cpu_rdata;
    logic          cpu_stall;
    logic          cpu_misalign;

    logic          dma_valid;
    logic          dma_ready;
    logic          dma_we;
    logic [3:0]    dma_be;
    logic [AW-1:0] dma_addr;
    logic [31:0]   dma_wdata;
    logic          dma_rvalid;
    logic [31:0]   dma_rdata;

    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [31:0]   mem_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_misalign,
        input  dma_valid, dma_we, dma_be, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_unsigned, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_misalign,
        output dma_valid, dma_we, dma_be, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the CPU load/store unit (priority) and a
// DMA loader, with CPU sub-word lane handling and a DMA starvation bound.
module dmem_arbiter #(
    parameter int AW           = 14,
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = 4
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave bus
);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt;
    logic          force_dma;
    logic          gnt_dma;
    logic          gnt_cpu;
    logic          misaligned;
    logic [1:0]    off;
    logic [31:0]   lane;
    logic          rd_vld_p1;
    logic [31:0]   rd_data_p1;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            default: return a != 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] size, input logic uns,
                                                input logic [31:0] ln);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = ln[7:0];
        h = ln[15:0];
        case (size)
            2'd0: begin
                s = b;
                return uns ? {24'b0, ln[7:0]} : s;
            end
            2'd1: begin
                s = h;
                return uns ? {16'b0, ln[15:0]} : s;
            end
            default: return ln;
        endcase
    endfunction

    // Grant: CPU wins unless DMA has been starved up to the limit.
    always_comb begin
        force_dma = bus.dma_valid && (starve_cnt == LIMIT);
        gnt_dma   = bus.dma_valid && (!bus.cpu_req || force_dma);
        gnt_cpu   = bus.cpu_req && !gnt_dma;
    end

    assign off              = bus.cpu_addr[1:0];
    assign misaligned       = is_misaligned(bus.cpu_size, off);
    assign lane             = bus.mem_dout >> {off, 3'b000};
    assign bus.cpu_misalign = bus.cpu_req && misaligned;
    assign bus.cpu_stall    = bus.cpu_req && gnt_dma;
    assign bus.dma_ready    = gnt_dma;
    assign bus.dma_rvalid   = rd_vld_p1;
    assign bus.dma_rdata    = rd_data_p1;

    always_comb begin
        bus.mem_en    = gnt_cpu || gnt_dma;
        bus.mem_we    = 4'b0000;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_din   = store_replicate(bus.cpu_size, bus.cpu_wdata);
        bus.cpu_rdata = 32'h0;
        if (gnt_dma) begin
            bus.mem_addr = bus.dma_addr;
            bus.mem_din  = bus.dma_wdata;
            bus.mem_we   = bus.dma_we ? bus.dma_be : 4'b0000;
        end else if (gnt_cpu && !misaligned) begin
            if (bus.cpu_we)
                bus.mem_we = store_be(bus.cpu_size, off);
            else
                bus.cpu_rdata = load_extend(bus.cpu_size, bus.cpu_unsigned, lane);
        end
    end

    // p1: starvation count and registered DMA read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            rd_vld_p1  <= 1'b0;
            rd_data_p1 <= 32'h0;
        end else begin
            if (!bus.dma_valid || gnt_dma)
                starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
                starve_cnt <= starve_cnt + CW'(1);
            rd_vld_p1 <= gnt_dma && !bus.dma_we;
            if (gnt_dma && !bus.dma_we)
                rd_data_p1 <= bus.mem_dout;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: CPU sizing vectors from a table, DMA reads checked
// through a scoreboard, plus starvation and asynchronous reset sequences.
module tb_dmem_arbiter;
    localparam int AW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(AW)) bus ();

    dmem_arbiter #(.AW(AW), .STARVE_LIMIT(8), .CW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:4095];
    assign bus.mem_dout = mem[bus.mem_addr[AW-1:2]];
    always @(posedge clk) begin
        if (bus.mem_en)
            for (int i = 0; i < 4; i++)
                if (bus.mem_we[i]) mem[bus.mem_addr[AW-1:2]][8*i +: 8] <= bus.mem_din[8*i +: 8];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;
    sb_t sb_q[$];

    // DMA read scoreboard: every rvalid must match the oldest expected word, on time.
    always @(posedge clk) begin
        #2;
        if (bus.dma_rvalid) begin
            if (sb_q.size() == 0) begin
                check("dma_rvalid_unexpected", 32'(bus.dma_rvalid), 32'h0);
            end else begin
                check("dma_rdata", bus.dma_rdata, sb_q[0].data);
                check("dma_rvalid_cycle", 32'(cyc), 32'(sb_q[0].due));
                void'(sb_q.pop_front());
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            check("dma_rvalid_missing", 32'(bus.dma_rvalid), 32'h1);
            void'(sb_q.pop_front());
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [3:0]  exp_we;
        logic [31:0] exp_val;
        logic        exp_mis;
    } vec_t;
    vec_t vecs[$];

    task automatic idle_inputs();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_size = 2'd2; bus.cpu_unsigned = 1'b0;
        bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_valid = 1'b0; bus.dma_we = 1'b0; bus.dma_be = 4'h0; bus.dma_addr = '0;
        bus.dma_wdata = '0;
    endtask

    task automatic dma_op(input logic we, input logic [3:0] be, input logic [13:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd);
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.dma_valid = 1'b1; bus.dma_we = we; bus.dma_be = be;
        bus.dma_addr = addr; bus.dma_wdata = wd;
        #1;
        check("dma_ready", 32'(bus.dma_ready), 32'h1);
        check("dma_mem_we", 32'(bus.mem_we), 32'(we ? be : 4'h0));
        if (!we) sb_q.push_back('{exp_rd, cyc + 1});
    endtask

    initial begin
        idle_inputs();
        #2;
        check("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'h0);
        check("rst_dma_rdata", bus.dma_rdata, 32'h0);
        check("rst_starve_cnt", 32'(dut.starve_cnt), 32'h0);
        check("rst_mem_en", 32'(bus.mem_en), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        dma_op(1'b1, 4'hF, 14'h020, 32'h11223344, 32'h0);
        dma_op(1'b1, 4'hF, 14'h024, 32'h55667788, 32'h0);
        dma_op(1'b1, 4'hF, 14'h028, 32'h11111111, 32'h0);
        check("dma_mem_din", bus.mem_din, 32'h11111111);
        @(negedge clk);
        idle_inputs();

        // we, size, uns, addr, wdata, exp_we, exp_val (din for stores, rdata for loads), exp_mis
        vecs.push_back('{1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 14'h013, 32'h00000080, 4'h8, 32'h80808080, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 14'h013, 32'h0,        4'h0, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 14'h013, 32'h0,        4'h0, 32'h00000080, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 14'h011, 32'h0,        4'h0, 32'h00000000, 1'b1});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 14'h012, 32'h12345678, 4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 14'h010, 32'h0,        4'h0, 32'h80ADBEEF, 1'b0});
        vecs.push_back('{1'b1, 2'd2, 1'b0, 14'h014, 32'h00000000, 4'hF, 32'h00000000, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 14'h016, 32'h0000A5C3, 4'hC, 32'hA5C3A5C3, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 14'h016, 32'h0,        4'h0, 32'hFFFFA5C3, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 14'h016, 32'h0,        4'h0, 32'h0000A5C3, 1'b0});
        vecs.push_back('{1'b0, 2'd3, 1'b0, 14'h014, 32'h0,        4'h0, 32'hA5C30000, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 14'h011, 32'h0,        4'h0, 32'hFFFFFFBE, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b1, 14'h012, 32'h0,        4'h0, 32'h000000AD, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b0, 14'h010, 32'h0,        4'h0, 32'hFFFFBEEF, 1'b0});
        vecs.push_back('{1'b0, 2'd1, 1'b1, 14'h012, 32'h0,        4'h0, 32'h000080AD, 1'b0});
        vecs.push_back('{1'b1, 2'd0, 1'b0, 14'h014, 32'h0000007F, 4'h1, 32'h7F7F7F7F, 1'b0});
        vecs.push_back('{1'b0, 2'd0, 1'b0, 14'h014, 32'h0,        4'h0, 32'h0000007F, 1'b0});
        vecs.push_back('{1'b1, 2'd1, 1'b0, 14'h015, 32'h0000FFFF, 4'h0, 32'h0,        1'b1});
        vecs.push_back('{1'b0, 2'd2, 1'b0, 14'h014, 32'h0,        4'h0, 32'hA5C3007F, 1'b0});

        foreach (vecs[i]) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = vecs[i].we; bus.cpu_size = vecs[i].size;
            bus.cpu_unsigned = vecs[i].uns; bus.cpu_addr = vecs[i].addr;
            bus.cpu_wdata = vecs[i].wdata;
            #1;
            check($sformatf("v%0d_misalign", i), 32'(bus.cpu_misalign), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'h0);
            check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
            if (!vecs[i].we)
                check($sformatf("v%0d_rdata", i), bus.cpu_rdata, vecs[i].exp_val);
            else if (!vecs[i].exp_mis)
                check($sformatf("v%0d_mem_din", i), bus.mem_din, vecs[i].exp_val);
        end
        @(negedge clk);
        idle_inputs();

        // Starvation: CPU holds a load, DMA waits until the forced grant in cycle 9.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_size = 2'd2; bus.cpu_addr = 14'h010;
            bus.dma_valid = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 14'h020;
            #1;
            check($sformatf("starve_c%0d_cnt", c), 32'(dut.starve_cnt),
                  (c <= 9) ? 32'(c - 1) : 32'h0);
            check($sformatf("starve_c%0d_ready", c), 32'(bus.dma_ready), 32'(c == 9));
            check($sformatf("starve_c%0d_stall", c), 32'(bus.cpu_stall), 32'(c == 9));
            if (c == 9) begin
                check("starve_mem_addr", 32'(bus.mem_addr), 32'h020);
                check("starve_cpu_rdata", bus.cpu_rdata, 32'h0);
                sb_q.push_back('{32'h11223344, cyc + 1});
            end
        end
        @(negedge clk);
        idle_inputs();

        dma_op(1'b0, 4'h0, 14'h020, 32'h0, 32'h11223344);
        dma_op(1'b0, 4'h0, 14'h024, 32'h0, 32'h55667788);
        dma_op(1'b1, 4'h5, 14'h028, 32'hAABBCCDD, 32'h0);
        check("dma_be_mem_din", bus.mem_din, 32'hAABBCCDD);
        dma_op(1'b0, 4'h0, 14'h028, 32'h0, 32'h11BB11DD);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        check("sb_drained_b2b", 32'(sb_q.size()), 32'h0);

        // Reset lands in a DMA read accept cycle while the previous rvalid is high.
        dma_op(1'b0, 4'h0, 14'h024, 32'h0, 32'h55667788);
        @(negedge clk);
        bus.dma_addr = 14'h020;
        #2;
        check("pre_rst_rvalid", 32'(bus.dma_rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(bus.dma_rvalid), 32'h0);
        check("mid_rst_rdata", bus.dma_rdata, 32'h0);
        check("mid_rst_cnt", 32'(dut.starve_cnt), 32'h0);
        check("mid_rst_ready", 32'(bus.dma_ready), 32'h1);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Reset clears a partially built-up starvation count.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_addr = 14'h010; bus.dma_valid = 1'b1;
            bus.dma_addr = 14'h020;
        end
        #1;
        check("pre_rst_cnt", 32'(dut.starve_cnt), 32'h3);
        rst_n = 1'b0;
        #1;
        check("rst_cnt_cleared", 32'(dut.starve_cnt), 32'h0);
        check("rst_ready_follows", 32'(bus.dma_ready), 32'h0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained_final", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
